// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared PS/2 definitions for the host transmitter and the receiver path:
//   - ps2_tx_state_t : transmitter FSM state encoding
//   - PS2_* constants: common command / response byte codes
//   - ps2_odd_parity : odd parity bit for one data byte
// ----------------------------------------------------------------------------
package ps2_pkg;

   // State codes are plain constants so legacy code can reuse the encoding.
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_INHIBIT  = 3'd1;
   localparam logic [2:0] ST_START    = 3'd2;
   localparam logic [2:0] ST_SHIFT    = 3'd3;
   localparam logic [2:0] ST_ACK      = 3'd4;
   localparam logic [2:0] ST_WAIT_REL = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE     = ST_IDLE,
      S_INHIBIT  = ST_INHIBIT,
      S_START    = ST_START,
      S_SHIFT    = ST_SHIFT,
      S_ACK      = ST_ACK,
      S_WAIT_REL = ST_WAIT_REL
   } ps2_tx_state_t;

   localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
   localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
   localparam logic [7:0] PS2_ACK         = 8'hFA;
   localparam logic [7:0] PS2_BREAK       = 8'hF0;
   localparam logic [7:0] PS2_EXT         = 8'hE0;

   // Odd parity: the 9-bit word (data + parity) carries an odd number of ones.
   function automatic logic ps2_odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ----------------------------------------------------------------------------
// ps2_line_sync
// Brings the raw PS/2 clock/data pins into the system clock domain and flags
// falling edges of the clock line. Shared by the transmitter and receiver.
// Ports:
//   clk_i, rst_i    : system clock, asynchronous active-low reset
//   ps2_clk_i       : raw clock pin (asynchronous)
//   ps2_data_i      : raw data pin (asynchronous)
//   clk_sync_o      : synchronized clock level
//   data_sync_o     : synchronized data level
//   fall_o          : registered one-cycle falling-edge flag, 3 cycles after
//                     the pin edge
// ----------------------------------------------------------------------------
module ps2_line_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic ps2_clk_i,
   input  logic ps2_data_i,
   output logic clk_sync_o,
   output logic data_sync_o,
   output logic fall_o
);

   logic r_clk_s1, r_clk_s2, r_clk_s3;
   logic r_data_s1, r_data_s2;
   logic r_fall;

   // Synchronizers reset to the idle (released, high) level so that leaving
   // reset never looks like a falling edge.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_clk_s1  <= 1'b1;
         r_clk_s2  <= 1'b1;
         r_clk_s3  <= 1'b1;
         r_data_s1 <= 1'b1;
         r_data_s2 <= 1'b1;
         r_fall    <= 1'b0;
      end else begin
         r_clk_s1  <= ps2_clk_i;
         r_clk_s2  <= r_clk_s1;
         r_clk_s3  <= r_clk_s2;
         r_data_s1 <= ps2_data_i;
         r_data_s2 <= r_data_s1;
         r_fall    <= r_clk_s3 & ~r_clk_s2;
      end
   end

   assign clk_sync_o  = r_clk_s2;
   assign data_sync_o = r_data_s2;
   assign fall_o      = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// ----------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte using the
// request-to-send sequence: inhibit clock, start bit, 8 data bits LSB first
// on device clock falls, odd parity, stop (release), device acknowledge.
// Ports:
//   clk_i, rst_i         : system clock, asynchronous active-low reset
//   data_i, data_val_i   : byte to send and request (taken only when ready_o)
//   ready_o              : idle, can accept a byte
//   done_o / err_o       : one-cycle result pulses (acked / aborted)
//   ps2_clk_i/ps2_data_i : raw pin levels
//   ps2_clk_oe_o         : 1 pulls the clock pin low
//   ps2_data_oe_o        : 1 pulls the data pin low
// ----------------------------------------------------------------------------
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int INHIBIT_US  = 100,
   parameter int TIMEOUT_US  = 20000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] data_i,
   input  logic       data_val_i,
   output logic       ready_o,
   output logic       done_o,
   output logic       err_o,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe_o,
   output logic       ps2_data_oe_o
);

   localparam int INHIBIT_CYC = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
   localparam int TIMEOUT_CYC = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
   localparam int INH_W       = $clog2(INHIBIT_CYC) + 1;
   localparam int TMO_W       = $clog2(TIMEOUT_CYC) + 1;

   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC);

   ps2_tx_state_t    r_state;
   logic [7:0]       r_data;
   logic             r_parity;
   logic [3:0]       r_bit_cnt;
   logic [INH_W-1:0] r_inh_cnt;
   logic [TMO_W-1:0] r_tmo;
   logic             r_clk_oe;
   logic             r_data_oe;
   logic             r_done;
   logic             r_err;

   logic w_clk_s, w_data_s, w_fall;
   logic w_ready;
   logic w_bit;

   ps2_line_sync u_sync (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .ps2_clk_i   (ps2_clk_i),
      .ps2_data_i  (ps2_data_i),
      .clk_sync_o  (w_clk_s),
      .data_sync_o (w_data_s),
      .fall_o      (w_fall)
   );

   // Ready is held low during the result pulse so a new request can only be
   // taken once the previous outcome has been reported.
   assign w_ready = (r_state == S_IDLE) & ~r_done & ~r_err;

   // Bit to present after the current fall: data[0..7], then parity.
   assign w_bit = r_bit_cnt[3] ? r_parity : r_data[r_bit_cnt[2:0]];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state   <= S_IDLE;
         r_data    <= '0;
         r_parity  <= 1'b0;
         r_bit_cnt <= '0;
         r_inh_cnt <= '0;
         r_tmo     <= '0;
         r_clk_oe  <= 1'b0;
         r_data_oe <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (data_val_i && w_ready) begin
                  r_data    <= data_i;
                  r_parity  <= ps2_odd_parity(data_i);
                  r_clk_oe  <= 1'b1;
                  r_inh_cnt <= '0;
                  r_state   <= S_INHIBIT;
               end
            end

            S_INHIBIT: begin
               if (r_inh_cnt == INH_LAST) begin
                  r_data_oe <= 1'b1;          // start bit
                  r_tmo     <= TMO_LOAD;
                  r_state   <= S_START;
               end else begin
                  r_inh_cnt <= r_inh_cnt + 1'b1;
               end
            end

            S_START, S_SHIFT, S_ACK, S_WAIT_REL: begin
               // One shared watchdog covers every wait on the device; it
               // sits at zero until expiry is acted on, so it cannot wrap.
               if (r_tmo == '0) begin
                  r_err     <= 1'b1;
                  r_clk_oe  <= 1'b0;
                  r_data_oe <= 1'b0;
                  r_state   <= S_IDLE;
               end else begin
                  r_tmo <= r_tmo - 1'b1;
                  case (r_state)
                     S_START: begin
                        r_clk_oe  <= 1'b0;    // hand the clock to the device
                        r_bit_cnt <= '0;
                        r_state   <= S_SHIFT;
                     end
                     S_SHIFT: begin
                        if (w_fall) begin
                           r_tmo <= TMO_LOAD;
                           if (r_bit_cnt == 4'd9) begin
                              r_data_oe <= 1'b0;   // stop bit: release
                              r_state   <= S_ACK;
                           end else begin
                              r_data_oe <= ~w_bit;
                              r_bit_cnt <= r_bit_cnt + 1'b1;
                           end
                        end
                     end
                     S_ACK: begin
                        if (w_fall) begin
                           if (!w_data_s) begin
                              r_tmo   <= TMO_LOAD;
                              r_state <= S_WAIT_REL;
                           end else begin
                              r_err   <= 1'b1;
                              r_state <= S_IDLE;
                           end
                        end
                     end
                     default: begin           // S_WAIT_REL
                        if (w_clk_s && w_data_s) begin
                           r_done  <= 1'b1;
                           r_state <= S_IDLE;
                        end
                     end
                  endcase
               end
            end

            default: begin
               r_clk_oe  <= 1'b0;
               r_data_oe <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   assign ready_o       = w_ready;
   assign done_o        = r_done;
   assign err_o         = r_err;
   assign ps2_clk_oe_o  = r_clk_oe;
   assign ps2_data_oe_o = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_ps2_host_tx
// Directed bench for ps2_host_tx with a PS/2 device model clocking at a
// 40-cycle period (1 MHz system clock). Expected frames and result pulses are
// queued when a transfer is issued; a monitor pops them as the device
// completes a frame or the DUT pulses done/err.
// ----------------------------------------------------------------------------
module tb_ps2_host_tx;
   import ps2_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] data_i;
   logic       data_val;
   logic       ready, done, err, clk_oe, data_oe;
   logic       dev_clk_low  = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       clk_line, data_line;

   // Open-drain wired-AND of host and device pull-downs.
   assign clk_line  = ~(clk_oe  | dev_clk_low);
   assign data_line = ~(data_oe | dev_data_low);

   always #5 clk = ~clk;

   ps2_host_tx #(
      .CLK_FREQ_HZ (1_000_000),
      .INHIBIT_US  (100),
      .TIMEOUT_US  (2000)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst_n),
      .data_i        (data_i),
      .data_val_i    (data_val),
      .ready_o       (ready),
      .done_o        (done),
      .err_o         (err),
      .ps2_clk_i     (clk_line),
      .ps2_data_i    (data_line),
      .ps2_clk_oe_o  (clk_oe),
      .ps2_data_oe_o (data_oe)
   );

   int  n_chk = 0;
   int  n_pass = 0;
   int  evt_seen = 0;
   int  dev_bit = -1;
   bit  dev_abort = 1'b0;

   logic [1:0] exp_evt_q[$];     // 2'b10 done, 2'b01 err
   logic [9:0] exp_frame_q[$];   // {stop, parity, data[7:0]}
   logic [9:0] obs_frame_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      logic [1:0] e;
      logic [9:0] of, ef;
      if (done || err) begin
         if (exp_evt_q.size() == 0) chk("pulse_expected", exp_evt_q.size(), 1);
         else begin
            e = exp_evt_q.pop_front();
            chk("result_pulse", {30'd0, done, err}, {30'd0, e});
         end
         evt_seen++;
      end
      if (obs_frame_q.size() > 0) begin
         of = obs_frame_q.pop_front();
         if (exp_frame_q.size() == 0) chk("frame_expected", exp_frame_q.size(), 1);
         else begin
            ef = exp_frame_q.pop_front();
            chk("device_frame", {22'd0, of}, {22'd0, ef});
         end
      end
   end

   // Device: waits for request-to-send, clocks 11 periods, samples data on
   // each rising edge (10 bits) and optionally pulls data low for the ack.
   task automatic dev_run(input bit do_ack);
      int n;
      logic [9:0] fr;
      fr = '0;
      dev_bit = -1;
      n = 0;
      while (!(clk_line && !data_line) && n < 500 && !dev_abort) begin
         @(negedge clk); n++;
      end
      chk("dev_saw_rts", {31'd0, n < 500}, 1);
      repeat (10) @(negedge clk);
      for (int i = 0; i < 11; i++) begin
         if (dev_abort) break;
         if (i == 10 && do_ack) dev_data_low = 1'b1;
         dev_bit = i;
         dev_clk_low = 1'b1;
         repeat (20) @(negedge clk);
         dev_clk_low = 1'b0;
         if (i < 10) fr[i] = data_line;
         repeat (20) @(negedge clk);
      end
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      if (!dev_abort) obs_frame_q.push_back(fr);
   endtask

   task automatic request(input logic [7:0] d);
      @(negedge clk);
      data_i = d;
      data_val = 1'b1;
      @(negedge clk);
      data_val = 1'b0;
   endtask

   task automatic wait_result();
      int n;
      int start;
      start = evt_seen;
      n = 0;
      while (!(done || err) && n < 3000) begin
         @(negedge clk); n++;
      end
      chk("result_in_time", {31'd0, n < 3000}, 1);
      chk("lines_released_at_result", {30'd0, clk_oe, data_oe}, 0);
      @(negedge clk);
      chk("ready_after_result", {31'd0, ready}, 1);
      repeat (5) @(negedge clk);
      chk("one_result_per_xfer", evt_seen - start, 1);
   endtask

   // Full transfer with a responsive device; par is the hand-computed parity.
   task automatic xfer(input logic [7:0] d, input bit par, input bit ack,
                       input bit busy, input bit timing);
      int n;
      exp_frame_q.push_back({1'b1, par, d});
      exp_evt_q.push_back(ack ? 2'b10 : 2'b01);
      fork
         dev_run(ack);
      join_none
      request(d);
      if (timing) begin
         chk("clk_oe_1_after_accept", {31'd0, clk_oe}, 1);
         n = 0;
         while (!data_oe && n < 300) begin
            @(negedge clk); n++;
         end
         chk("inhibit_cycles", n, 100);
         chk("clk_oe_held_at_start", {31'd0, clk_oe}, 1);
         @(negedge clk);
         chk("clk_release_after_start", {31'd0, clk_oe}, 0);
      end
      if (busy) begin
         n = 0;
         while (dev_bit < 4 && n < 1000) begin
            @(negedge clk); n++;
         end
         chk("busy_not_ready", {31'd0, ready}, 0);
         data_i = 8'h55;
         data_val = 1'b1;
         @(negedge clk);
         data_val = 1'b0;
      end
      wait_result();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0;
      data_i = 8'h00;
      data_val = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, ready}, 1);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_err", {31'd0, err}, 0);
      chk("rst_clk_oe", {31'd0, clk_oe}, 0);
      chk("rst_data_oe", {31'd0, data_oe}, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // 0xED -> bits 1,0,1,1,0,1,1,1, six ones -> parity 1
      xfer(PS2_CMD_SET_LED, 1'b1, 1'b1, 1'b0, 1'b1);
      xfer(8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
      xfer(8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      xfer(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);

      // Request while shifting 0x3C (four ones -> parity 1) must be dropped.
      xfer(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("busy_no_new_xfer", {31'd0, clk_oe}, 0);

      // No ack: 0x81, two ones -> parity 1.
      xfer(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);

      // Silent device: error 2000 cycles after clock release.
      exp_evt_q.push_back(2'b01);
      request(8'h5A);
      n = 0;
      while (!data_oe && n < 300) begin
         @(negedge clk); n++;
      end
      @(negedge clk);
      chk("silent_clk_release", {31'd0, clk_oe}, 0);
      n = 0;
      while (!err && n < 2200) begin
         @(negedge clk); n++;
      end
      chk("silent_timeout_cycles", n, 2000);
      chk("silent_lines_released", {30'd0, clk_oe, data_oe}, 0);
      @(negedge clk);
      chk("silent_ready_after", {31'd0, ready}, 1);
      repeat (5) @(negedge clk);

      // Reset during bit 4 of 0xA5 (bit4 = 0, so data is pulled low).
      fork
         dev_run(1'b1);
      join_none
      request(8'hA5);
      n = 0;
      while (dev_bit < 4 && n < 2000) begin
         @(negedge clk); n++;
      end
      repeat (10) @(negedge clk);
      chk("bit4_driven_low", {31'd0, data_oe}, 1);
      #2;
      rst_n = 1'b0;
      dev_abort = 1'b1;
      #1;
      chk("async_rst_lines", {30'd0, clk_oe, data_oe}, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      dev_abort = 1'b0;
      chk("post_rst_outputs", {27'd0, ready, done, err, clk_oe, data_oe}, 32'h10);

      xfer(PS2_CMD_RESET, 1'b1, 1'b1, 1'b0, 1'b0);

      repeat (20) @(negedge clk);
      chk("all_results_seen", exp_evt_q.size(), 0);
      chk("all_frames_seen", exp_frame_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
